exc_commit: RTL and testbench
=============================

// Module: exc_commit
// PURPOSE
//  Exception/ERET commit unit at the MEM->WB boundary, directly upstream of the CP0 register file.
//  Prioritises the fault flags of the instruction in MEM, merges the pending-interrupt level from CP0,
//  drives the CP0 exception-update bus and flushes the pipeline.
//  Issues a held redirect (exception vector or EPC) to fetch with a valid/ready handshake.
// PARAMETERS
//  VEC_BEV1   32'hBFC0_0380  exception entry when Status.BEV=1
//  VEC_BEV0   32'h8000_0180  exception entry when Status.BEV=0
//  CNT_W      16             width of the taken-exception counter
// PORTS
//  clk             in   1   clock; all state updates on the posedge
//  reset           in   1   synchronous, active-high
//  mem_valid       in   1   MEM holds a live instruction
//  mem_pc          in   32  PC of that instruction
//  mem_bd          in   1   instruction is in a branch delay slot
//  mem_if_adel     in   1   fetch address error
//  mem_ri          in   1   reserved instruction
//  mem_ov          in   1   arithmetic overflow
//  mem_sys         in   1   syscall
//  mem_bp          in   1   break
//  mem_eret        in   1   eret
//  mem_d_adel      in   1   load address error
//  mem_d_ades      in   1   store address error
//  mem_vaddr       in   32  data virtual address
//  int_pending     in   1   CP0 ext_int_response (level)
//  cp0_bev         in   1   Status.BEV
//  cp0_epc         in   32  current EPC
//  exc_valid       out  1   CP0 update strobe
//  exc_excode      out  5   CP0 ExcCode
//  exc_bd          out  1   CP0 branch-delay flag
//  exc_epc         out  32  CP0 EPC value
//  exc_badvaddr    out  32  CP0 BadVAddr value
//  exc_eret        out  1   CP0 eret strobe
//  flush           out  1   kill IF..MEM; suppress MEM write-back/store
//  redirect_valid  out  1   redirect request to fetch
//  redirect_pc     out  32  redirect target
//  redirect_ready  in   1   fetch accepts the redirect
//  exc_count       out  CNT_W  taken exceptions/erets, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; redirect_pc=0; exc_count=0.
//  Reset dominates every other event, including mid-REDIRECT; the pending redirect is dropped.
//  FSM IDLE, REDIRECT.
//  - In IDLE, an event fires when mem_valid & (int_pending | any fault flag | mem_eret).
//  - Priority, highest first, with ExcCode:
//    Int 0x00 > IF AdEL 0x04 > RI 0x0a > Ov 0x0c > Sys 0x08 > Bp 0x09 > ERET > D AdEL 0x04 > D AdES 0x05.
//  - Interrupts are taken only on a valid instruction. With mem_valid=0 they are deferred; no latch is
//    needed because int_pending is a level.
//  Event cycle (IDLE, combinational, one-cycle pulse):
//  - exc_valid=1; flush=1.
//  - exc_eret=1 only when ERET wins.
//  - exc_bd=mem_bd.
//  - exc_epc = mem_bd ? mem_pc-32'd4 : mem_pc (mod 2^32).
//  - exc_badvaddr = mem_pc for IF AdEL, mem_vaddr for D AdEL/AdES, 0 otherwise.
//  - At the edge: redirect_pc <= ERET ? cp0_epc : (cp0_bev ? VEC_BEV1 : VEC_BEV0);
//    exc_count++ (saturates at all-ones); state -> REDIRECT.
//  REDIRECT:
//  - redirect_valid=1 and flush=1; exc_valid=0.
//  - MEM inputs are ignored, as is int_pending.
//  - redirect_pc is stable until accepted.
//  - redirect_valid&redirect_ready -> IDLE at the next edge.
//  - Latency: redirect_valid rises 1 cycle after the event; minimum event-to-event spacing is 2 cycles.
//  - No event in IDLE: all strobes 0; redirect_valid=0.
//  - exc_excode is 0 whenever exc_valid=0.
// TESTING
//  - Overflow: mem_valid, mem_ov, mem_pc=0x8000_1000, bd=0, bev=1 -> exc_valid 1 cycle, excode 0x0c,
//    epc 0x8000_1000; next cycle redirect_pc 0xBFC0_0380.
//  - Delay-slot load fault: mem_d_adel, mem_bd=1, mem_pc=0x8000_2004, vaddr=0x1003 -> excode 0x04,
//    epc 0x8000_2000, badvaddr 0x1003.
//  - Int vs Sys: int_pending with mem_sys=1 -> excode 0x00. Same with mem_valid=0 -> no exc_valid until
//    a valid instruction arrives.
//  - ERET, cp0_epc=0x8000_3000, bev=0 -> exc_eret=1, redirect_pc 0x8000_3000. Held 3 cycles with
//    redirect_ready=0: redirect_valid and redirect_pc stable, new faults ignored.
//  - Reset asserted during REDIRECT -> next cycle redirect_valid=0, state IDLE, exc_count=0.
//  - 2^CNT_W+2 events -> exc_count saturates at all-ones.

Source files
------------

// File: rtl/exc_commit_if.sv
// ---------------------------------------------------------------------------
// exc_commit_if
//   Bundle between the exception/ERET commit unit and its surroundings: the
//   MEM-stage instruction and its fault flags, the CP0 state that is read,
//   the CP0 exception-update bus, the pipeline flush and the fetch redirect
//   handshake.
//   master : the commit unit (consumes MEM/CP0 state, drives CP0 bus + redirect)
//   slave  : the pipeline/CP0/fetch side (the opposite directions)
// ---------------------------------------------------------------------------
interface exc_commit_if #(
    parameter int CNT_W = 16
);
    // MEM-stage instruction
    logic             mem_valid;
    logic [31:0]      mem_pc;
    logic             mem_bd;
    logic             mem_if_adel;
    logic             mem_ri;
    logic             mem_ov;
    logic             mem_sys;
    logic             mem_bp;
    logic             mem_eret;
    logic             mem_d_adel;
    logic             mem_d_ades;
    logic [31:0]      mem_vaddr;
    // CP0 state
    logic             int_pending;
    logic             cp0_bev;
    logic [31:0]      cp0_epc;
    // CP0 exception-update bus
    logic             exc_valid;
    logic [4:0]       exc_excode;
    logic             exc_bd;
    logic [31:0]      exc_epc;
    logic [31:0]      exc_badvaddr;
    logic             exc_eret;
    // pipeline control / fetch redirect
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;
    logic [CNT_W-1:0] exc_count;

    modport master (
        input  mem_valid, mem_pc, mem_bd, mem_if_adel, mem_ri, mem_ov, mem_sys,
               mem_bp, mem_eret, mem_d_adel, mem_d_ades, mem_vaddr,
               int_pending, cp0_bev, cp0_epc, redirect_ready,
        output exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
               flush, redirect_valid, redirect_pc, exc_count
    );

    modport slave (
        output mem_valid, mem_pc, mem_bd, mem_if_adel, mem_ri, mem_ov, mem_sys,
               mem_bp, mem_eret, mem_d_adel, mem_d_ades, mem_vaddr,
               int_pending, cp0_bev, cp0_epc, redirect_ready,
        input  exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
               flush, redirect_valid, redirect_pc, exc_count
    );
endinterface

// File: rtl/exc_commit.sv
// ---------------------------------------------------------------------------
// exc_commit
//   Exception/ERET commit unit at the MEM->WB boundary. Picks the winning
//   event of the instruction in MEM (interrupt level merged in), pulses the
//   CP0 exception-update bus for one cycle, flushes the pipeline and then
//   holds a redirect (exception vector or EPC) towards fetch until accepted.
// Ports
//   clk    : clock, all state on posedge
//   reset  : synchronous, active-high; drops any pending redirect
//   bus    : exc_commit_if.master (MEM flags, CP0 state, CP0 bus, redirect)
// Parameters
//   VEC_BEV1 / VEC_BEV0 : exception entry for Status.BEV = 1 / 0
//   CNT_W               : width of the saturating taken-event counter
// ---------------------------------------------------------------------------
module exc_commit #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC0_0380,
    parameter logic [31:0] VEC_BEV0 = 32'h8000_0180,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    exc_commit_if.master  bus
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

    // Winning event of the MEM instruction, listed in priority order.
    typedef enum logic [3:0] {
        W_NONE, W_INT, W_IF_ADEL, W_RI, W_OV, W_SYS, W_BP, W_ERET, W_D_ADEL, W_D_ADES
    } win_t;

    state_t           state_q, state_d;
    win_t             win;
    logic             fire;
    logic [4:0]       excode;
    logic [31:0]      badvaddr;
    logic [31:0]      epc;
    logic [31:0]      target;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat;

    // ---- priority resolve --------------------------------------------------
    // Interrupt is a level from CP0: if MEM is empty it is simply seen again
    // on the next valid instruction, so nothing is latched here.
    always_comb begin
        win = W_NONE;
        if      (bus.int_pending) win = W_INT;
        else if (bus.mem_if_adel) win = W_IF_ADEL;
        else if (bus.mem_ri)      win = W_RI;
        else if (bus.mem_ov)      win = W_OV;
        else if (bus.mem_sys)     win = W_SYS;
        else if (bus.mem_bp)      win = W_BP;
        else if (bus.mem_eret)    win = W_ERET;
        else if (bus.mem_d_adel)  win = W_D_ADEL;
        else if (bus.mem_d_ades)  win = W_D_ADES;
    end

    always_comb begin
        excode   = EXC_INT;
        badvaddr = 32'd0;
        case (win)
            W_IF_ADEL: begin excode = EXC_ADEL; badvaddr = bus.mem_pc;    end
            W_RI:            excode = EXC_RI;
            W_OV:            excode = EXC_OV;
            W_SYS:           excode = EXC_SYS;
            W_BP:            excode = EXC_BP;
            W_D_ADEL:  begin excode = EXC_ADEL; badvaddr = bus.mem_vaddr; end
            W_D_ADES:  begin excode = EXC_ADES; badvaddr = bus.mem_vaddr; end
            default:         excode = EXC_INT;   // Int, ERET, none
        endcase
    end

    // Delay-slot instructions restart at the branch; wraps mod 2^32.
    assign epc    = bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
    assign target = (win == W_ERET) ? bus.cp0_epc
                                    : (bus.cp0_bev ? VEC_BEV1 : VEC_BEV0);

    // Events are only accepted in IDLE; in REDIRECT the MEM stage is being
    // flushed so whatever it holds is dead.
    assign fire = !reset && (state_q == IDLE) && bus.mem_valid && (win != W_NONE);

    // ---- FSM next state / outputs -----------------------------------------
    always_comb begin
        state_d            = state_q;
        bus.exc_valid      = 1'b0;
        bus.exc_excode     = 5'd0;
        bus.exc_bd         = 1'b0;
        bus.exc_epc        = 32'd0;
        bus.exc_badvaddr   = 32'd0;
        bus.exc_eret       = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    bus.exc_valid    = 1'b1;
                    bus.exc_excode   = excode;
                    bus.exc_bd       = bus.mem_bd;
                    bus.exc_epc      = epc;
                    bus.exc_badvaddr = badvaddr;
                    bus.exc_eret     = (win == W_ERET);
                    bus.flush        = 1'b1;
                    state_d          = REDIRECT;
                end
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.flush          = 1'b1;
                if (bus.redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over a pending redirect: nothing leaves the block.
        if (reset) begin
            bus.redirect_valid = 1'b0;
            bus.flush          = 1'b0;
            state_d            = IDLE;
        end
    end

    assign cnt_sat = &cnt_q;

    // ---- state ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            redirect_pc_q <= 32'd0;
            cnt_q         <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                // Captured once; held untouched until fetch takes it.
                redirect_pc_q <= target;
                if (!cnt_sat) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.redirect_pc = redirect_pc_q;
    assign bus.exc_count   = cnt_q;

endmodule

// File: tb/tb_exc_commit.sv
module tb_exc_commit;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exc_commit_if #(.CNT_W(CNT_W)) bus ();

    exc_commit #(
        .VEC_BEV1 (32'hBFC0_0380),
        .VEC_BEV0 (32'h8000_0180),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- reference model --------------------------------------------------
    bit          m_busy;   // a redirect is outstanding
    logic [31:0] m_rpc;
    int          m_cnt;

    typedef struct packed {
        logic        fire;
        logic        eret;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] bva;
        logic        rv;
        logic        fl;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        bit   req [9];
        int   codes [9];
        int   w;
        e = '0;
        codes = '{0, 4, 10, 12, 8, 9, 0, 4, 5};
        req   = '{bus.int_pending, bus.mem_if_adel, bus.mem_ri, bus.mem_ov, bus.mem_sys,
                  bus.mem_bp, bus.mem_eret, bus.mem_d_adel, bus.mem_d_ades};
        w = -1;
        for (int i = 8; i >= 0; i--) if (req[i]) w = i;
        e.rv = m_busy && !reset;
        e.fl = e.rv;
        if (!m_busy && !reset && bus.mem_valid && w >= 0) begin
            e.fire = 1'b1;
            e.fl   = 1'b1;
            e.eret = (w == 6);
            e.code = codes[w][4:0];
            e.bd   = bus.mem_bd;
            e.epc  = bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
            e.bva  = (w == 1) ? bus.mem_pc : ((w == 7 || w == 8) ? bus.mem_vaddr : 32'd0);
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        e = model_eval();
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_rpc = 32'd0; m_cnt = 0;
        end else if (e.fire) begin
            m_busy = 1;
            m_rpc  = e.eret ? bus.cp0_epc : (bus.cp0_bev ? 32'hBFC0_0380 : 32'h8000_0180);
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (m_busy && bus.redirect_ready) begin
            m_busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_bd = 0; bus.mem_if_adel = 0;
        bus.mem_ri = 0; bus.mem_ov = 0; bus.mem_sys = 0; bus.mem_bp = 0; bus.mem_eret = 0;
        bus.mem_d_adel = 0; bus.mem_d_ades = 0; bus.mem_vaddr = 0; bus.int_pending = 0;
        bus.cp0_bev = 0; bus.cp0_epc = 0; bus.redirect_ready = 0;
    endtask

    // accept any outstanding redirect (bounded)
    task automatic drain();
        clear_inputs();
        bus.redirect_ready = 1;
        for (int i = 0; i < 4 && m_busy; i++) tick();
        bus.redirect_ready = 0;
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL drain: redirect_valid=%b want 0", bus.redirect_valid);
        end
    endtask

    // ---- tests -------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1;
        bus.mem_valid = 1; bus.mem_ov = 1; bus.int_pending = 1;
        tick(); tick();
        #1;
        checks++;
        if ({bus.exc_valid, bus.flush, bus.redirect_valid, bus.exc_eret} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: v/fl/rv/eret=%b want 0000",
                {bus.exc_valid, bus.flush, bus.redirect_valid, bus.exc_eret});
        end
        checks++;
        if (bus.exc_count !== '0 || bus.redirect_pc !== 32'd0 || bus.exc_excode !== 5'd0) begin
            errors++; $display("FAIL reset_regs: cnt=%0d rpc=%h code=%h want 0",
                bus.exc_count, bus.redirect_pc, bus.exc_excode);
        end
        clear_inputs();
        reset = 0;
        tick();
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.exc_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: rv=%b v=%b want 0", bus.redirect_valid, bus.exc_valid);
        end
    endtask

    task automatic test_overflow();
        clear_inputs();
        bus.mem_valid = 1; bus.mem_ov = 1; bus.mem_pc = 32'h8000_1000; bus.cp0_bev = 1;
        #1;
        checks++;
        if (bus.exc_valid !== 1'b1 || bus.exc_excode !== 5'h0c || bus.exc_epc !== 32'h8000_1000
            || bus.flush !== 1'b1 || bus.exc_eret !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL ov_event: v=%b code=%h epc=%h fl=%b eret=%b rv=%b want 1 0c 80001000 1 0 0",
                bus.exc_valid, bus.exc_excode, bus.exc_epc, bus.flush, bus.exc_eret, bus.redirect_valid);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.exc_valid !== 1'b0 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC0_0380
            || bus.flush !== 1'b1) begin
            errors++; $display("FAIL ov_redirect: v=%b rv=%b rpc=%h fl=%b want 0 1 bfc00380 1",
                bus.exc_valid, bus.redirect_valid, bus.redirect_pc, bus.flush);
        end
        drain();
    endtask

    task automatic test_dslot_load();
        clear_inputs();
        bus.mem_valid = 1; bus.mem_d_adel = 1; bus.mem_bd = 1;
        bus.mem_pc = 32'h8000_2004; bus.mem_vaddr = 32'h0000_1003;
        #1;
        checks++;
        if (bus.exc_valid !== 1'b1 || bus.exc_excode !== 5'h04 || bus.exc_epc !== 32'h8000_2000
            || bus.exc_badvaddr !== 32'h1003 || bus.exc_bd !== 1'b1) begin
            errors++; $display("FAIL dslot_load: v=%b code=%h epc=%h bva=%h bd=%b want 1 04 80002000 1003 1",
                bus.exc_valid, bus.exc_excode, bus.exc_epc, bus.exc_badvaddr, bus.exc_bd);
        end
        tick();
        drain();
    endtask

    task automatic test_int_vs_sys();
        clear_inputs();
        bus.mem_valid = 1; bus.int_pending = 1; bus.mem_sys = 1;
        #1;
        checks++;
        if (bus.exc_valid !== 1'b1 || bus.exc_excode !== 5'h00) begin
            errors++; $display("FAIL int_vs_sys: v=%b code=%h want 1 00", bus.exc_valid, bus.exc_excode);
        end
        tick();
        drain();
        bus.mem_valid = 0; bus.int_pending = 1; bus.mem_sys = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.exc_valid !== 1'b0) begin
                errors++; $display("FAIL int_deferred[%0d]: v=%b want 0", i, bus.exc_valid);
            end
            tick();
        end
        bus.mem_valid = 1;
        #1;
        checks++;
        if (bus.exc_valid !== 1'b1 || bus.exc_excode !== 5'h00) begin
            errors++; $display("FAIL int_taken: v=%b code=%h want 1 00", bus.exc_valid, bus.exc_excode);
        end
        tick();
        drain();
    endtask

    task automatic test_eret_hold();
        int cnt0;
        clear_inputs();
        cnt0 = m_cnt;
        bus.mem_valid = 1; bus.mem_eret = 1; bus.cp0_epc = 32'h8000_3000; bus.cp0_bev = 0;
        #1;
        checks++;
        if (bus.exc_valid !== 1'b1 || bus.exc_eret !== 1'b1) begin
            errors++; $display("FAIL eret_event: v=%b eret=%b want 1 1", bus.exc_valid, bus.exc_eret);
        end
        tick();
        // new faults, interrupt and a changed EPC must all be ignored while held
        bus.mem_eret = 0; bus.mem_ov = 1; bus.mem_ri = 1; bus.int_pending = 1;
        bus.cp0_epc = 32'h1234_5678; bus.redirect_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h8000_3000 || bus.exc_valid !== 1'b0
                || bus.exc_excode !== 5'd0 || bus.flush !== 1'b1) begin
                errors++; $display("FAIL eret_hold[%0d]: rv=%b rpc=%h v=%b code=%h fl=%b want 1 80003000 0 00 1",
                    i, bus.redirect_valid, bus.redirect_pc, bus.exc_valid, bus.exc_excode, bus.flush);
            end
            tick();
        end
        checks++;
        if (int'(bus.exc_count) !== ((cnt0 < CNT_MAX) ? cnt0 + 1 : CNT_MAX)) begin
            errors++; $display("FAIL eret_count: cnt=%0d want %0d", bus.exc_count,
                (cnt0 < CNT_MAX) ? cnt0 + 1 : CNT_MAX);
        end
        drain();
    endtask

    task automatic test_reset_mid_redirect();
        clear_inputs();
        bus.mem_valid = 1; bus.mem_bp = 1; bus.cp0_bev = 1;
        tick();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.exc_count !== '0 || bus.redirect_pc !== 32'd0) begin
            errors++; $display("FAIL reset_mid: rv=%b cnt=%0d rpc=%h want 0 0 0",
                bus.redirect_valid, bus.exc_count, bus.redirect_pc);
        end
        tick();
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: rv=%b fl=%b want 0 0", bus.redirect_valid, bus.flush);
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int n = 0; n < 400; n++) begin
            bus.mem_valid   = ($urandom_range(0, 3) != 0);
            bus.mem_pc      = $urandom;
            bus.mem_bd      = $urandom_range(0, 1);
            bus.mem_if_adel = ($urandom_range(0, 7) == 0);
            bus.mem_ri      = ($urandom_range(0, 7) == 0);
            bus.mem_ov      = ($urandom_range(0, 7) == 0);
            bus.mem_sys     = ($urandom_range(0, 7) == 0);
            bus.mem_bp      = ($urandom_range(0, 7) == 0);
            bus.mem_eret    = ($urandom_range(0, 7) == 0);
            bus.mem_d_adel  = ($urandom_range(0, 7) == 0);
            bus.mem_d_ades  = ($urandom_range(0, 7) == 0);
            bus.mem_vaddr   = $urandom;
            bus.int_pending = ($urandom_range(0, 9) == 0);
            bus.cp0_bev     = $urandom_range(0, 1);
            bus.cp0_epc     = $urandom;
            bus.redirect_ready = $urandom_range(0, 1);
            reset = ($urandom_range(0, 49) == 0);
            #1;
            e = model_eval();
            checks++;
            if (bus.exc_valid !== e.fire || bus.exc_eret !== e.eret || bus.flush !== e.fl
                || bus.redirect_valid !== e.rv) begin
                errors++; $display("FAIL rnd_strobe[%0d]: v/eret/fl/rv=%b%b%b%b want %b%b%b%b", n,
                    bus.exc_valid, bus.exc_eret, bus.flush, bus.redirect_valid, e.fire, e.eret, e.fl, e.rv);
            end
            checks++;
            if ((!e.eret && bus.exc_excode !== e.code) || bus.exc_bd !== e.bd || bus.exc_epc !== e.epc
                || bus.exc_badvaddr !== e.bva) begin
                errors++; $display("FAIL rnd_cp0[%0d]: code=%h bd=%b epc=%h bva=%h want %h %b %h %h", n,
                    bus.exc_excode, bus.exc_bd, bus.exc_epc, bus.exc_badvaddr, e.code, e.bd, e.epc, e.bva);
            end
            checks++;
            if (bus.redirect_pc !== m_rpc || int'(bus.exc_count) !== m_cnt) begin
                errors++; $display("FAIL rnd_regs[%0d]: rpc=%h cnt=%0d want %h %0d", n,
                    bus.redirect_pc, bus.exc_count, m_rpc, m_cnt);
            end
            tick();
        end
        reset = 0;
        drain();
    endtask

    task automatic test_saturation();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        for (int k = 1; k <= (1 << CNT_W) + 2; k++) begin
            bus.mem_valid = 1; bus.mem_sys = 1; bus.redirect_ready = 1;
            tick();
            bus.mem_valid = 0; bus.mem_sys = 0;
            tick();
            checks++;
            if (int'(bus.exc_count) !== ((k < CNT_MAX) ? k : CNT_MAX)) begin
                errors++; $display("FAIL sat_count[%0d]: cnt=%0d want %0d", k, bus.exc_count,
                    (k < CNT_MAX) ? k : CNT_MAX);
            end
        end
        checks++;
        if (bus.exc_count !== {CNT_W{1'b1}}) begin
            errors++; $display("FAIL sat_final: cnt=%0d want %0d", bus.exc_count, CNT_MAX);
        end
        drain();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_busy = 0; m_rpc = 32'd0; m_cnt = 0;
        reset = 1;
        clear_inputs();
        test_reset();
        test_overflow();
        test_dslot_load();
        test_int_vs_sys();
        test_eret_hold();
        test_reset_mid_redirect();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
